// File: rtl/commit_trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : commit_trace_fifo
//  Purpose  : First-word-fall-through buffer for retired-instruction writeback
//             events. Each record is tagged with a commit sequence number.
//             Records that arrive while the buffer is full are dropped, counted
//             and flagged.
//  Revision : 1.0 - initial release
// ============================================================================
module commit_trace_fifo #(
    parameter int DEPTH  = 16,
    parameter int AWIDTH = 32,
    parameter int SEQ_W  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    w_valid,
    input  logic [AWIDTH-1:0]       w_pc,
    input  logic                    w_enable,
    input  logic [4:0]              w_destination,
    input  logic [AWIDTH-1:0]       w_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEQ_W-1:0]        out_seq,
    output logic [AWIDTH-1:0]       out_pc,
    output logic                    out_enable,
    output logic [4:0]              out_destination,
    output logic [AWIDTH-1:0]       out_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic [15:0]             drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] c_count_full = CNT_W'(DEPTH);
    localparam logic [15:0]      c_drop_max   = 16'hFFFF;

    // ------------------------------------------------------------------------
    // Record storage (no reset: contents are only visible while count != 0)
    // ------------------------------------------------------------------------
    logic [SEQ_W-1:0]  mem_seq_q  [DEPTH];
    logic [AWIDTH-1:0] mem_pc_q   [DEPTH];
    logic              mem_en_q   [DEPTH];
    logic [4:0]        mem_dst_q  [DEPTH];
    logic [AWIDTH-1:0] mem_data_q [DEPTH];

    // ------------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,     rd_ptr_d;
    logic [CNT_W-1:0] count_q,      count_d;
    logic [SEQ_W-1:0] seq_q,        seq_d;
    logic             overflow_q,   overflow_d;
    logic [15:0]      drop_count_q, drop_count_d;

    logic             w_not_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_en_n;
    logic [AWIDTH-1:0] w_data_n;

    assign w_not_empty = (count_q != '0);
    assign w_full      = (count_q == c_count_full);
    assign w_pop       = w_not_empty & out_ready;
    // A full buffer still accepts a record when the head leaves in the same cycle.
    assign w_push      = w_valid & (~w_full | w_pop);
    assign w_drop      = w_valid & w_full & ~w_pop;

    // Writes to x0 are architecturally meaningless; present them as no-writes.
    assign w_en_n      = w_enable & (w_destination != 5'd0);
    assign w_data_n    = w_en_n ? w_data : '0;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        seq_d        = seq_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (w_push && !w_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            count_d = count_q - CNT_W'(1);
        end

        // Sequence advances for dropped records too, leaving a visible gap.
        if (w_valid) begin
            seq_d = seq_q + SEQ_W'(1);
        end

        if (w_drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != c_drop_max) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            seq_q        <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            seq_q        <= seq_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            mem_seq_q[wr_ptr_q]  <= seq_q;
            mem_pc_q[wr_ptr_q]   <= w_pc;
            mem_en_q[wr_ptr_q]   <= w_en_n;
            mem_dst_q[wr_ptr_q]  <= w_destination;
            mem_data_q[wr_ptr_q] <= w_data_n;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: head entry fall-through, forced to zero while empty
    // ------------------------------------------------------------------------
    always_comb begin
        out_valid       = w_not_empty;
        out_seq         = '0;
        out_pc          = '0;
        out_enable      = 1'b0;
        out_destination = '0;
        out_data        = '0;
        if (w_not_empty) begin
            out_seq         = mem_seq_q[rd_ptr_q];
            out_pc          = mem_pc_q[rd_ptr_q];
            out_enable      = mem_en_q[rd_ptr_q];
            out_destination = mem_dst_q[rd_ptr_q];
            out_data        = mem_data_q[rd_ptr_q];
        end
    end

    assign count      = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule
`default_nettype wire

// File: doc/commit_trace_fifo.md
Name: commit_trace_fifo

Overview:
Buffers retired-instruction writeback events from the pipeline's W stage (PC, write enable, destination, data) so the trace/check side can drain them at its own pace. Sits directly downstream of design_wrapper's writeback probe points, upstream of the trace writer. Tags each record with a commit sequence number. Counts and flags dropped records on overflow.

Parameters:
DEPTH, 16, FIFO entries; power of 2, at least 2
AWIDTH, 32, PC and data width
SEQ_W, 32, sequence-number width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
w_valid  in  1  one instruction retires this cycle
w_pc  in  AWIDTH  PC of retiring instruction
w_enable  in  1  register-file write enable of retiring instruction
w_destination  in  5  destination register index
w_data  in  AWIDTH  writeback data
out_valid  out  1  head record available
out_ready  in  1  consumer accepts head record
out_seq  out  SEQ_W  head record sequence number
out_pc  out  AWIDTH  head record PC
out_enable  out  1  head record write enable (normalised)
out_destination  out  5  head record destination
out_data  out  AWIDTH  head record data (normalised)
count  out  log2(DEPTH)+1  occupied entries
overflow  out  1  sticky: at least one record dropped since reset
drop_count  out  16  dropped records, saturating at 0xFFFF

Behaviour:
- Reset (async, active-high): pointers, count, seq counter, overflow and drop_count go to 0; out_valid=0; out_* data fields read 0. Reset mid-stream discards all stored records; next accepted record gets seq 0.
- Push: on a rising clk edge with w_valid=1 and a free slot, write {seq, w_pc, en_n, w_destination, data_n}; seq counter increments by 1, wrapping mod 2^SEQ_W.
- Normalisation: en_n = w_enable AND (w_destination != 0); data_n = w_data when en_n=1, else 0. The destination field is stored unmodified.
- Pop: on a rising clk edge with out_valid=1 and out_ready=1, the head advances. out_ready while out_valid=0 has no effect.
- Output: out_* show the head entry combinationally from storage (first-word fall-through). A record pushed into an empty FIFO appears at out_valid=1 one cycle after the capturing edge, i.e. visible in the cycle after w_valid was sampled.
- out_valid = (count != 0). Head fields stay stable while out_valid=1 and out_ready=0.
- Full with simultaneous push and pop: both occur; count stays DEPTH; no drop.
- Full with push and no pop: record dropped; seq counter still increments, so the consumer sees a gap; overflow set (sticky until reset); drop_count increments, saturating at 0xFFFF.
- Empty with simultaneous push and pop: pop ignored (out_valid=0); push occurs; count becomes 1.
- count updates: +1 on push only, -1 on pop only, unchanged on both or neither; range 0..DEPTH.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty are decided by count, not by pointer equality.

Test Plan:
- Reset, then w_valid=1 once with pc=0x01000000, en=1, rd=5, data=0xDEADBEEF, out_ready=0 -> next cycle out_valid=1, out_seq=0, out_pc=0x01000000, out_enable=1, out_destination=5, out_data=0xDEADBEEF, count=1.
- Push with rd=0, en=1, data=0x1234 -> record shows out_enable=0, out_destination=0, out_data=0.
- out_ready=0, push 20 records with DEPTH=16 -> count=16, overflow=1, drop_count=4; drain yields seq 0..15 in order; the next push after draining gets seq 20.
- FIFO full, push with out_ready=1 in the same cycle -> count stays 16, drop_count unchanged, new record stored at the tail.
- Continuous w_valid=1 and out_ready=1 for 100 cycles -> count at most 1, seq 0..99 delivered in order, overflow=0.
- 5 records queued, assert reset asynchronously mid-cycle -> out_valid=0 and count=0 immediately, before the next clk edge; first post-reset record has seq 0.
